// File: rtl/registrador_universal.sv
// rtl/registrador_universal.sv - parametrised universal shift register with word counter
// Shift/rotate/load/clear storage; Count tracks serial shifts and Word_done pulses per WIDTH-bit word.
module registrador_universal #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [2:0]       Mode,
   input  logic             Shift_in_msb,
   input  logic             Shift_in_lsb,
   input  logic [WIDTH-1:0] Data_in,
   output logic [WIDTH-1:0] Q,
   output logic             Shift_out_r,
   output logic             Shift_out_l,
   output logic [CW-1:0]    Count,
   output logic             Word_done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;

   localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_next;
   logic [CW-1:0]    count_next;
   logic             word_done_next;
   logic             is_shift;
   logic             last_shift;

   assign is_shift   = (Mode == MODE_SHR) || (Mode == MODE_SHL);
   assign last_shift = is_shift && (Count == COUNT_LAST);

   always_comb begin
      q_next         = Q;
      count_next     = Count;
      word_done_next = 1'b0;
      if (Enable) begin
         case (Mode)
            MODE_SHR:  q_next = {Shift_in_msb, Q[WIDTH-1:1]};
            MODE_SHL:  q_next = {Q[WIDTH-2:0], Shift_in_lsb};
            MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
            MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
            MODE_LOAD: q_next = Data_in;
            MODE_CLR:  q_next = '0;
            MODE_HOLD: q_next = Q;
            default:   q_next = Q;
         endcase
         // Counting is direction-agnostic; the last shift of a word wraps and flags it.
         if (is_shift) begin
            count_next     = last_shift ? '0 : Count + CW'(1);
            word_done_next = last_shift;
         end else if ((Mode == MODE_LOAD) || (Mode == MODE_CLR)) begin
            count_next = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         Q         <= '0;
         Count     <= '0;
         Word_done <= 1'b0;
      end else begin
         Q         <= q_next;
         Count     <= count_next;
         Word_done <= word_done_next;
      end
   end

   assign Shift_out_r = Q[0];
   assign Shift_out_l = Q[WIDTH-1];

endmodule

// File: tb/tb_registrador_universal.sv
// tb/tb_registrador_universal.sv - scoreboard bench for registrador_universal
// Stimulus pushes model predictions; a monitor pops and compares one per clock edge.
module tb_registrador_universal;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   logic          CLK = 1'b0;
   logic          Reset = 1'b0;
   logic          Enable = 1'b0;
   logic [2:0]    Mode = 3'b000;
   logic          Shift_in_msb = 1'b0;
   logic          Shift_in_lsb = 1'b0;
   logic [W-1:0]  Data_in = '0;
   logic [W-1:0]  Q;
   logic          Shift_out_r;
   logic          Shift_out_l;
   logic [CW-1:0] Count;
   logic          Word_done;

   registrador_universal #(.WIDTH(W)) dut (
      .CLK(CLK), .Reset(Reset), .Enable(Enable), .Mode(Mode),
      .Shift_in_msb(Shift_in_msb), .Shift_in_lsb(Shift_in_lsb), .Data_in(Data_in),
      .Q(Q), .Shift_out_r(Shift_out_r), .Shift_out_l(Shift_out_l),
      .Count(Count), .Word_done(Word_done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] q;
      int           cnt;
      bit           wd;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] mq = '0;
   int           mc = 0;
   bit           mw = 1'b0;

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("mon_q", Q, e.q);
         chk("mon_count", Count, e.cnt);
         chk("mon_word_done", Word_done, e.wd);
         chk("mon_out_r", Shift_out_r, e.q[0]);
         chk("mon_out_l", Shift_out_l, e.q[W-1]);
      end
   end

   // Behavioural model: shifts as arithmetic, count as shifts modulo W.
   task automatic step(input bit rst, input bit en, input logic [2:0] md,
                       input bit msb, input bit lsb, input logic [W-1:0] din);
      exp_t e;
      @(negedge CLK);
      Reset = rst; Enable = en; Mode = md;
      Shift_in_msb = msb; Shift_in_lsb = lsb; Data_in = din;
      if (!rst) begin
         mq = '0; mc = 0; mw = 1'b0;
      end else if (!en) begin
         mw = 1'b0;
      end else begin
         mw = 1'b0;
         case (md)
            3'd1: mq = (mq >> 1) | (W'(msb) << (W - 1));
            3'd2: mq = (mq << 1) | W'(lsb);
            3'd3: mq = (mq >> 1) | (W'(mq[0]) << (W - 1));
            3'd4: mq = (mq << 1) | W'(mq[W-1]);
            3'd5: begin mq = din; mc = 0; end
            3'd6: begin mq = '0;  mc = 0; end
            default: ;
         endcase
         if (md == 3'd1 || md == 3'd2) begin
            mw = (mc == W - 1);
            mc = (mc + 1) % W;
         end
      end
      e.q = mq; e.cnt = mc; e.wd = mw;
      sb.push_back(e);
   endtask

   task automatic pulse_reset();
      exp_t e;
      @(negedge CLK);
      Enable = 1'b0;
      #1 Reset = 1'b0;
      #1;
      chk("async_rst_q", Q, 0);
      chk("async_rst_count", Count, 0);
      chk("async_rst_wd", Word_done, 0);
      Reset = 1'b1;
      mq = '0; mc = 0; mw = 1'b0;
      e.q = mq; e.cnt = mc; e.wd = mw;
      sb.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] sin_r;
      logic [7:0] out_r;
      logic [7:0] rol_exp [3];
      sin_r = 8'b0100_1101;
      out_r = 8'b1010_0101;
      rol_exp[0] = 8'h03; rol_exp[1] = 8'h06; rol_exp[2] = 8'h0C;

      #1;
      chk("reset_q", Q, 0);
      chk("reset_count", Count, 0);
      chk("reset_wd", Word_done, 0);

      for (int i = 0; i < 3; i++) step(0, 1, 3'd5, 0, 0, 8'hFF);
      step(1, 1, 3'd5, 0, 0, 8'hFF);
      after_edge();
      chk("release_load", Q, 8'hFF);

      // SIPO/PISO right: input bits LSB-first from sin_r, expected Shift_out_r LSB-first from out_r.
      step(1, 1, 3'd5, 0, 0, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 3'd1, sin_r[i], 0, '0);
         chk("piso_r_out", Shift_out_r, out_r[i]);
      end
      after_edge();
      chk("right_q", Q, 8'h4D);
      chk("right_count", Count, 0);
      chk("right_wd", Word_done, 1);
      step(1, 1, 3'd0, 0, 0, '0);
      after_edge();
      chk("right_wd_clear", Word_done, 0);

      step(1, 1, 3'd5, 0, 0, 8'h01);
      for (int i = 0; i < 7; i++) step(1, 1, 3'd2, 0, 0, '0);
      after_edge();
      chk("left_q7", Q, 8'h80);
      chk("left_out_l", Shift_out_l, 1);
      chk("left_count7", Count, 7);
      chk("left_wd7", Word_done, 0);
      step(1, 1, 3'd2, 0, 0, '0);
      after_edge();
      chk("left_q8", Q, 8'h00);
      chk("left_wd8", Word_done, 1);

      step(1, 1, 3'd5, 0, 0, 8'h81);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 3'd4, 0, 0, '0);
         after_edge();
         chk("rol_q", Q, rol_exp[i]);
         chk("rol_count", Count, 0);
      end
      step(1, 1, 3'd5, 0, 0, 8'h81);
      step(1, 1, 3'd3, 0, 0, '0);
      after_edge();
      chk("ror_q", Q, 8'hC0);

      step(1, 1, 3'd5, 0, 0, 8'h0F);
      step(1, 1, 3'd2, 0, 0, '0);
      step(1, 1, 3'd2, 0, 0, '0);
      for (int i = 0; i < 5; i++) step(1, 0, 3'd1, 1, 1, '0);
      step(1, 1, 3'd7, 1, 1, 8'hAA);
      after_edge();
      chk("en_rsv_q", Q, 8'h3C);
      chk("en_rsv_count", Count, 2);

      step(1, 1, 3'd6, 0, 0, '0);
      for (int i = 0; i < 5; i++) step(1, 1, 3'd1, 1, 0, '0);
      after_edge();
      chk("midword_count5", Count, 5);
      pulse_reset();
      for (int i = 0; i < 7; i++) step(1, 1, 3'd2, 0, 1, '0);
      after_edge();
      chk("midword_wd7", Word_done, 0);
      step(1, 1, 3'd1, 1, 0, '0);
      after_edge();
      chk("midword_wd8", Word_done, 1);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset();
         else step(1, ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), W'($urandom));
      end

      repeat (3) @(posedge CLK);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/registrador_universal.md
# registrador_universal

Parametrised universal shift register, successor to the fixed 4-bit serial-in register. It provides WIDTH-bit storage with shift-left and shift-right, rotate, parallel load and clear modes, serial inputs and outputs at both ends, and a shift counter that flags each completed WIDTH-bit serial word. It sits between serial links and parallel datapaths as a SIPO/PISO converter.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CW, $clog2(WIDTH), width of Count (localparam, not overridable).

- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  when 0, all state holds regardless of Mode.
- Mode  input  3  operation select; see Operation.
- Shift_in_msb  input  1  serial bit entering Q[WIDTH-1] on shift right.
- Shift_in_lsb  input  1  serial bit entering Q[0] on shift left.
- Data_in  input  WIDTH  parallel load value.
- Q  output  WIDTH  register contents; registered.
- Shift_out_r  output  1  equals Q[0]; combinational from Q.
- Shift_out_l  output  1  equals Q[WIDTH-1]; combinational from Q.
- Count  output  CW  shifts completed in the current word, 0..WIDTH-1; registered.
- Word_done  output  1  one-cycle pulse marking a completed word; registered.

## Operation
- Mode encoding (applies only when Enable=1):
  - 000 hold.
  - 001 shift right: Q <= {Shift_in_msb, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], Shift_in_lsb}.
  - 011 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 100 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 parallel load: Q <= Data_in.
  - 110 clear: Q <= 0.
  - 111 reserved; behaves as hold.
- Counter:
  - Shift modes (001, 010) increment Count.
  - When Count = WIDTH-1, a shift wraps Count to 0 and sets Word_done for the next cycle.
  - Load (101) and clear (110) set Count to 0 and cancel any pending word.
  - Rotate, hold and reserved modes leave Count unchanged.
  - Shift direction may change mid-word; Count is direction-agnostic.
- Word_done is 1 in exactly the cycle following the edge that completed the word, otherwise 0. Back-to-back words produce pulses WIDTH cycles apart.
- Enable=0 holds Q and Count and forces Word_done to 0 at the next edge.

## Timing
- Reset=0: immediately and asynchronously, Q=0, Count=0, Word_done=0, so Shift_out_r=0 and Shift_out_l=0. Reset release is synchronous to CLK; the first operation takes effect at the first rising edge with Reset=1.
- Reset asserted mid-word discards the partial word; a full WIDTH shifts are needed afterwards for the next Word_done.
- Latency: Q, Count and Word_done reflect inputs sampled at edge N immediately after edge N (one-cycle).
- Shift_out_r and Shift_out_l change only when Q changes; there are no combinational paths from inputs.
- Inputs are sampled only at rising CLK; changes between edges have no effect.
- Word_done pulse width is one cycle, even when Enable drops in the pulse cycle.

## Test plan
- Reset: drive Reset=0 with Mode=101 and Data_in=0xFF, toggling CLK -> Q=0x00, Count=0, Word_done=0 throughout; the first edge after release loads 0xFF.
- SIPO/PISO right: load 0xA5, then 8 shift-right edges with Shift_in_msb=1,0,1,1,0,0,1,0 -> before each edge Shift_out_r is 1,0,1,0,0,1,0,1; final Q=0x4D, Count=0; Word_done=1 for exactly the cycle after the 8th shift.
- Shift left: load 0x01, then 7 shift-left edges with Shift_in_lsb=0 -> Q=0x80, Shift_out_l=1, Count=7, Word_done=0; the 8th edge gives Q=0x00 and a Word_done pulse.
- Rotate: load 0x81, then 3 rotate-left edges -> Q=0x03, 0x06, 0x0C; Count stays 0, no Word_done. Rotate-right from 0x81 -> 0xC0.
- Enable and reserved: with Q=0x3C and Count=2, hold Enable=0 and Mode=001 for 5 edges -> Q=0x3C, Count=2; then Enable=1 and Mode=111 -> unchanged.
- Mid-word reset: after 5 shifts (Count=5), pulse Reset low between edges -> Q and Count go to 0 immediately; Word_done appears only after 8 further shifts.
